pll_ddr2_lock_seq: RTL
======================

Name: pll_ddr2_lock_seq

Overview:
- Reset/lock sequencer for the DDR2 rPLL: pulses the PLL reset, waits for lock, and qualifies lock as stable before releasing the DDR2 controller reset.
- Retries on lock timeout, and restarts when lock is lost while running.
- Runs on the free-running 25 MHz board clock that also feeds the PLL's clkin, so it never depends on PLL outputs.

Parameters:
- RESET_CYCLES, 16: cycles pll_reset stays high per attempt (1..65535).
- LOCK_TIMEOUT, 25000: cycles allowed from pll_reset deassert to stable lock per attempt (1 ms at 25 MHz).
- LOCK_STABLE, 256: consecutive cycles synchronised lock must be high to count as stable.
- DDR_RST_DELAY, 64: cycles between stable lock and ddr_rst_n release.
- MAX_RETRY, 3: failed attempts allowed after the first before FAIL (0..15).

Ports:
- clkin  in  1  25 MHz reference clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- pll_lock  in  1  rPLL lock output; asynchronous to clkin.
- relock_req  in  1  single-cycle request to force a full re-lock.
- pll_reset  out  1  drives rPLL reset, active-high.
- ddr_rst_n  out  1  DDR2 controller reset, active-low.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  4  failed attempts in the current sequence.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN.
- state  out  3  encoded state, for debug.

Behaviour:
- pll_lock passes through a 2-flop synchroniser (lock_s). All lock decisions use lock_s, so there are 2 cycles of latency from pll_lock to lock_s.
- Reset (reset_n low at a clkin edge):
  - Enters RST_PLL with counters 0 and synchroniser cleared.
  - Outputs: pll_reset=1, ddr_rst_n=0, ready=0, fail=0, retry_cnt=0, lock_lost=0, state=RST_PLL.
  - Reset mid-operation behaves identically from any state.
- State encoding: RST_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5.
- RST_PLL:
  - pll_reset=1 and ddr_rst_n=0.
  - After RESET_CYCLES cycles with reset_n high, go to WAIT_LOCK.
  - The timeout counter clears on entry to WAIT_LOCK.
- WAIT_LOCK:
  - pll_reset=0; the timeout counter increments each cycle.
  - lock_s=1 goes to STABLE, with the stable counter set to 1.
- STABLE:
  - lock_s=1 increments the stable counter; reaching LOCK_STABLE goes to RELEASE.
  - lock_s=0 returns to WAIT_LOCK, keeping the timeout count.
  - The timeout counter keeps running.
- Timeout: when the timeout counter reaches LOCK_TIMEOUT in WAIT_LOCK or STABLE:
  - If retry_cnt==MAX_RETRY, go to FAIL.
  - Otherwise retry_cnt+1 and go to RST_PLL.
  - Timeout takes priority over the same-cycle STABLE→RELEASE transition.
- RELEASE:
  - ddr_rst_n stays 0 for DDR_RST_DELAY cycles, then go to RUN.
  - lock_s=0 here is treated as a lock loss: retry_cnt+1, then RST_PLL, or FAIL if retry_cnt==MAX_RETRY.
- RUN:
  - ddr_rst_n=1, ready=1, retry_cnt cleared to 0 on entry.
  - lock_s=0: lock_lost pulses for 1 cycle, ddr_rst_n=0 on the next cycle, go to RST_PLL with retry_cnt=0.
- FAIL:
  - pll_reset=1, ddr_rst_n=0, fail=1.
  - Held until reset_n or relock_req.
- relock_req:
  - In any state except RST_PLL it goes to RST_PLL with retry_cnt=0; ignored in RST_PLL.
  - Takes priority over timeout and lock-loss events in the same cycle.
  - ddr_rst_n drops the cycle after it is sampled.
- Output timing:
  - All outputs are registered.
  - ddr_rst_n is never 1 unless in RUN.
  - pll_reset is 1 only in RST_PLL or FAIL.
- Counter widths: $clog2 of the relevant parameter +1. All counters saturate and never wrap.

Test Plan (RESET_CYCLES=4, LOCK_TIMEOUT=100, LOCK_STABLE=8, DDR_RST_DELAY=5, MAX_RETRY=2):
1. Release reset_n, pll_lock rises 10 cycles after pll_reset falls → pll_reset high exactly 4 cycles; ddr_rst_n rises 2+8+5 cycles after pll_lock; ready=1, retry_cnt=0.
2. pll_lock never asserts → three attempts of 4+100 cycles, with retry_cnt going 0,1,2; then fail=1, pll_reset=1, ddr_rst_n=0 held indefinitely.
3. pll_lock glitches low for 3 cycles during STABLE, then high → stable count restarts; RELEASE is entered only after 8 consecutive high lock_s cycles, and no retry occurs if still within 100 cycles.
4. In RUN, drop pll_lock → lock_lost is a single pulse 2 cycles later, ddr_rst_n=0 and ready=0 next cycle, pll_reset high 4 cycles, then re-lock succeeds.
5. In FAIL, pulse relock_req for 1 cycle → state=RST_PLL, retry_cnt=0, fail=0; sequence completes when pll_lock is driven high.
6. Assert reset_n low for 1 cycle during RELEASE → all outputs return to reset values next edge; the sequence restarts from RST_PLL.

Source files
------------

// File: rtl/pll_ddr2_lock_seq_if.sv
// Signal bundle between the DDR2 PLL lock sequencer and the rPLL/DDR2
// controller side. The clock and reset stay outside as plain ports.
interface pll_ddr2_lock_seq_if;
  logic       pll_lock;    // raw rPLL lock, asynchronous to clkin
  logic       relock_req;  // single-cycle forced re-lock
  logic       pll_reset;   // rPLL reset, active-high
  logic       ddr_rst_n;   // DDR2 controller reset, active-low
  logic       ready;       // sequencer in RUN
  logic       fail;        // sequencer in FAIL
  logic [3:0] retry_cnt;   // failed attempts in the current sequence
  logic       lock_lost;   // one-cycle pulse on lock drop in RUN
  logic [2:0] state;       // encoded state, debug only

  // Sequencer side
  modport master (
    input  pll_lock, relock_req,
    output pll_reset, ddr_rst_n, ready, fail, retry_cnt, lock_lost, state
  );

  // PLL / controller / monitor side
  modport slave (
    output pll_lock, relock_req,
    input  pll_reset, ddr_rst_n, ready, fail, retry_cnt, lock_lost, state
  );
endinterface

// File: rtl/pll_ddr2_lock_seq.sv
// DDR2 rPLL reset/lock sequencer. Pulses the PLL reset, waits for a lock that
// stays up long enough to trust, then releases the DDR2 controller reset after
// a settle delay. Retries on timeout, restarts on lock loss. Runs entirely on
// the free-running board clock so it never depends on the PLL it controls.
module pll_ddr2_lock_seq #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 25000,
  parameter int LOCK_STABLE   = 256,
  parameter int DDR_RST_DELAY = 64,
  parameter int MAX_RETRY     = 3
) (
  input  logic                clkin,
  input  logic                reset_n,
  pll_ddr2_lock_seq_if.master bus
);

  localparam int RST_W = $clog2(RESET_CYCLES) + 1;
  localparam int TMO_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam int STB_W = $clog2(LOCK_STABLE) + 1;
  localparam int REL_W = $clog2(DDR_RST_DELAY) + 1;

  // Terminal values: each counter is compared against its last in-range value
  // so the state dwell equals the parameter exactly.
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [RST_W-1:0] RST_ONE   = RST_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);
  localparam logic [STB_W-1:0] STB_TGT   = STB_W'(LOCK_STABLE);
  localparam logic [STB_W-1:0] STB_ONE   = STB_W'(1);
  localparam logic [REL_W-1:0] REL_LAST  = REL_W'(DDR_RST_DELAY - 1);
  localparam logic [REL_W-1:0] REL_ONE   = REL_W'(1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST_PLL   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic             lock_s;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d, rst_inc;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d, stb_inc;
  logic [REL_W-1:0] rel_cnt_q, rel_cnt_d, rel_inc;
  logic [3:0]       retry_q, retry_d;
  logic             lock_lost_d;
  logic             attempt_fail;

  logic             pll_reset_q, ddr_rst_n_q, ready_q, fail_q, lock_lost_q;

  assign lock_s = sync_q[1];

  // Saturating increments so no counter can ever wrap back into range.
  assign rst_inc = (rst_cnt_q == '1) ? rst_cnt_q : rst_cnt_q + RST_ONE;
  assign tmo_inc = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TMO_ONE;
  assign stb_inc = (stb_cnt_q == '1) ? stb_cnt_q : stb_cnt_q + STB_ONE;
  assign rel_inc = (rel_cnt_q == '1) ? rel_cnt_q : rel_cnt_q + REL_ONE;

  // Next-state and counter logic; event priority is relock > timeout/loss > normal.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    stb_cnt_d    = stb_cnt_q;
    rel_cnt_d    = rel_cnt_q;
    retry_d      = retry_q;
    lock_lost_d  = 1'b0;
    attempt_fail = 1'b0;

    case (state_q)
      S_RST_PLL: begin
        rst_cnt_d = rst_inc;
        if (rst_cnt_q == RST_LAST) begin
          state_d   = S_WAIT_LOCK;
          tmo_cnt_d = '0;
        end
      end
      S_WAIT_LOCK: begin
        tmo_cnt_d = tmo_inc;
        if (tmo_cnt_q == TMO_LAST) begin
          attempt_fail = 1'b1;
        end else if (lock_s) begin
          // The sample that brings us here already counts as the first.
          stb_cnt_d = STB_ONE;
          rel_cnt_d = '0;
          state_d   = (STB_ONE == STB_TGT) ? S_RELEASE : S_STABLE;
        end
      end
      S_STABLE: begin
        tmo_cnt_d = tmo_inc;
        if (tmo_cnt_q == TMO_LAST) begin
          attempt_fail = 1'b1;
        end else if (!lock_s) begin
          // Glitch: restart qualification but keep the attempt's time budget.
          state_d = S_WAIT_LOCK;
        end else begin
          stb_cnt_d = stb_inc;
          if (stb_inc == STB_TGT) begin
            state_d   = S_RELEASE;
            rel_cnt_d = '0;
          end
        end
      end
      S_RELEASE: begin
        if (!lock_s) begin
          attempt_fail = 1'b1;
        end else begin
          rel_cnt_d = rel_inc;
          if (rel_cnt_q == REL_LAST) begin
            state_d = S_RUN;
            retry_d = '0;
          end
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          lock_lost_d = 1'b1;
          state_d     = S_RST_PLL;
          retry_d     = '0;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_RST_PLL;
      end
    endcase

    if (attempt_fail) begin
      if (retry_q >= RETRY_MAX) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + 4'd1;
        state_d = S_RST_PLL;
      end
    end

    // A relock request in RST_PLL would only restart a reset already in progress.
    if (bus.relock_req && (state_q != S_RST_PLL)) begin
      state_d     = S_RST_PLL;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end

    // Every entry into RST_PLL gets a full reset pulse.
    if ((state_d == S_RST_PLL) && (state_q != S_RST_PLL)) begin
      rst_cnt_d = '0;
    end
  end

  // Lock synchroniser, state/counter registers and registered outputs.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      sync_q      <= 2'b00;
      state_q     <= S_RST_PLL;
      rst_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      ddr_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.pll_lock};
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      retry_q     <= retry_d;
      // Outputs decode the next state so they line up with the state register.
      pll_reset_q <= (state_d == S_RST_PLL) || (state_d == S_FAIL);
      ddr_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.ddr_rst_n = ddr_rst_n_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.state     = state_q;

endmodule
